// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for issue-stage hazard detection.
module register_file_mp #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NR     = 2,
    parameter  int NW     = 1,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*XLEN-1:0] wd,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*XLEN-1:0] rd,
    output logic [NR-1:0]      rbusy,
    input  logic               claim_en,
    input  logic [AW-1:0]      claim_a,
    input  logic [AW-1:0]      dbg_a,
    output logic [XLEN-1:0]    dbg_d
);

    // x0 is hardwired, so storage starts at index 1.
    logic [XLEN-1:0]    regs_q [NREGS-1:1];
    logic [XLEN-1:0]    regs_d [NREGS-1:1];
    logic [NREGS-1:1]   busy_q;
    logic [NREGS-1:1]   busy_d;

    // Ascending port order lets the highest-index writer win a collision;
    // the claim is applied last so it overrides a same-cycle write's clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int w = 0; w < NW; w++) begin
                if (we[w] && (wa[w*AW +: AW] == AW'(r))) begin
                    regs_d[r] = wd[w*XLEN +: XLEN];
                    busy_d[r] = 1'b0;
                end
            end
            if (claim_en && (claim_a == AW'(r)))
                busy_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++)
                regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // A bypassed read reports not-busy even if it is claimed this cycle;
    // the claim only becomes visible through the stored busy bit.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int j = 0; j < NR; j++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (ra[j*AW +: AW] == AW'(r)) begin
                    rd[j*XLEN +: XLEN] = regs_q[r];
                    rbusy[j]           = busy_q[r];
                end
            end
            if (BYPASS && (ra[j*AW +: AW] != '0)) begin
                for (int w = 0; w < NW; w++) begin
                    if (we[w] && (wa[w*AW +: AW] == ra[j*AW +: AW])) begin
                        rd[j*XLEN +: XLEN] = wd[w*XLEN +: XLEN];
                        rbusy[j]           = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        dbg_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (dbg_a == AW'(r))
                dbg_d = regs_q[r];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed checks of register_file_mp: a two-write-port bypassing instance
// driven from a vector table, and a non-bypassing instance driven by hand.
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: NW=2, BYPASS=1
    logic [1:0]  a_we;
    logic [9:0]  a_wa;
    logic [63:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic        a_cen;
    logic [4:0]  a_ca;
    logic [4:0]  a_dbga;
    logic [31:0] a_dbgd;

    // Instance B: NW=1, BYPASS=0
    logic        b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rbusy;
    logic        b_cen;
    logic [4:0]  b_ca;
    logic [4:0]  b_dbga;
    logic [31:0] b_dbgd;

    register_file_mp #(.XLEN(32), .NREGS(32), .NR(2), .NW(2), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra),
        .rd(a_rd), .rbusy(a_rbusy), .claim_en(a_cen), .claim_a(a_ca),
        .dbg_a(a_dbga), .dbg_d(a_dbgd));

    register_file_mp #(.XLEN(32), .NREGS(32), .NR(2), .NW(1), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra),
        .rd(b_rd), .rbusy(b_rbusy), .claim_en(b_cen), .claim_a(b_ca),
        .dbg_a(b_dbga), .dbg_d(b_dbgd));

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        cen;
        logic [4:0]  ca;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  dbga;
        logic [31:0] e_rd0;
        logic        e_rb0;
        logic [31:0] e_rd1;
        logic        e_rb1;
        logic [31:0] e_dbg;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic r, input logic [1:0] w,
        input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic ce, input logic [4:0] ca,
        input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da,
        input logic [31:0] erd0, input logic erb0,
        input logic [31:0] erd1, input logic erb1, input logic [31:0] edbg);
        vec_t v;
        v.rst = r; v.we = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.cen = ce; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1; v.dbga = da;
        v.e_rd0 = erd0; v.e_rb0 = erb0; v.e_rd1 = erd1; v.e_rb1 = erb1; v.e_dbg = edbg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic b_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ce, input logic [4:0] ca, input logic [4:0] ra0);
        b_we = we; b_wa = wa; b_wd = wd; b_cen = ce; b_ca = ca;
        b_ra = {5'd0, ra0}; b_dbga = ra0;
    endtask

    task automatic b_check(input string nm, input logic [31:0] erd, input logic erb,
                           input logic [31:0] edbg);
        chk({nm, ".rd"},    b_rd[31:0],        erd);
        chk({nm, ".rbusy"}, {31'd0, b_rbusy[0]}, {31'd0, erb});
        chk({nm, ".dbg"},   b_dbgd,            edbg);
    endtask

    initial begin
        tv[0]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  5,  0,  5, 32'h0,        0, 32'h0,        0, 32'h0);
        tv[1]  = mk(0, 2'b01,  5, 32'hDEADBEEF,  0, 32'h0,         0,  0,  5,  1,  5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        tv[2]  = mk(1, 2'b01,  5, 32'h1,         0, 32'h0,         0,  0,  5,  5,  5, 32'h1,        0, 32'h1,        0, 32'hDEADBEEF);
        tv[3]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  5,  5,  5, 32'h0,        0, 32'h0,        0, 32'h0);
        tv[4]  = mk(0, 2'b11,  1, 32'h12345678,  0, 32'hFFFFFFFF,  0,  0,  1,  0,  0, 32'h12345678, 0, 32'h0,        0, 32'h0);
        tv[5]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  1,  0,  0, 32'h12345678, 0, 32'h0,        0, 32'h0);
        tv[6]  = mk(0, 2'b11,  3, 32'h11,        3, 32'h22,        0,  0,  3,  7,  1, 32'h22,       0, 32'h0,        0, 32'h12345678);
        tv[7]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  3,  7,  3, 32'h22,       0, 32'h0,        0, 32'h22);
        tv[8]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         1,  9,  9,  3,  0, 32'h0,        0, 32'h22,       0, 32'h0);
        tv[9]  = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  9,  3,  0, 32'h0,        1, 32'h22,       0, 32'h0);
        tv[10] = mk(0, 2'b01,  9, 32'h55,        0, 32'h0,         0,  0,  9,  9,  9, 32'h55,       0, 32'h55,       0, 32'h0);
        tv[11] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  9,  9,  9, 32'h55,       0, 32'h55,       0, 32'h55);
        tv[12] = mk(0, 2'b10,  0, 32'h0,         9, 32'h55,        1,  9,  9,  3,  9, 32'h55,       0, 32'h22,       0, 32'h55);
        tv[13] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  9,  3,  9, 32'h55,       1, 32'h22,       0, 32'h55);
        tv[14] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         1,  0,  0,  9,  9, 32'h0,        0, 32'h55,       1, 32'h55);
        tv[15] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  0,  3,  9, 32'h0,        0, 32'h22,       0, 32'h55);
        tv[16] = mk(0, 2'b11, 10, 32'hAAAA,     11, 32'hBBBB,      0,  0, 10, 11, 10, 32'hAAAA,     0, 32'hBBBB,     0, 32'h0);
        tv[17] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0, 10, 11, 11, 32'hAAAA,     0, 32'hBBBB,     0, 32'hBBBB);
        tv[18] = mk(1, 2'b00,  0, 32'h0,         0, 32'h0,         1, 12,  9, 12, 10, 32'h55,       1, 32'h0,        0, 32'hAAAA);
        tv[19] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  9, 12, 10, 32'h0,        0, 32'h0,        0, 32'h0);
        tv[20] = mk(0, 2'b01,  4, 32'h44,        4, 32'h99,        0,  0,  4,  0,  4, 32'h44,       0, 32'h0,        0, 32'h0);
        tv[21] = mk(0, 2'b00,  0, 32'h0,         0, 32'h0,         0,  0,  4,  0,  4, 32'h44,       0, 32'h0,        0, 32'h44);

        rst = 1'b1;
        a_we = '0; a_wa = '0; a_wd = '0; a_ra = '0; a_cen = 1'b0; a_ca = '0; a_dbga = '0;
        b_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1;
            rst    = tv[i].rst;
            a_we   = tv[i].we;
            a_wa   = {tv[i].wa1, tv[i].wa0};
            a_wd   = {tv[i].wd1, tv[i].wd0};
            a_cen  = tv[i].cen;
            a_ca   = tv[i].ca;
            a_ra   = {tv[i].ra1, tv[i].ra0};
            a_dbga = tv[i].dbga;
            #1;
            chk($sformatf("v%0d.rd0", i),    a_rd[31:0],            tv[i].e_rd0);
            chk($sformatf("v%0d.rd1", i),    a_rd[63:32],           tv[i].e_rd1);
            chk($sformatf("v%0d.rbusy0", i), {31'd0, a_rbusy[0]},   {31'd0, tv[i].e_rb0});
            chk($sformatf("v%0d.rbusy1", i), {31'd0, a_rbusy[1]},   {31'd0, tv[i].e_rb1});
            chk($sformatf("v%0d.dbg", i),    a_dbgd,                tv[i].e_dbg);
            @(posedge clk);
        end

        // Non-bypassing instance: writes only appear through storage.
        #1; rst = 1'b0; a_we = '0; a_cen = 1'b0;
        b_drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7);
        #1; b_check("nobyp.w7", 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        b_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7);
        #1; b_check("nobyp.r7", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        b_drive(1'b1, 5'd7, 32'h5A, 1'b1, 5'd7, 5'd7);
        #1; b_check("nobyp.claimw7", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        b_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7);
        #1; b_check("nobyp.busy7", 32'h5A, 1'b1, 32'h5A);
        @(posedge clk); #1;
        b_drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7);
        #1; b_check("nobyp.wbusy7", 32'h5A, 1'b1, 32'h5A);
        @(posedge clk); #1;
        b_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7);
        #1; b_check("nobyp.free7", 32'h77, 1'b0, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the pipelined successor of the RISC-V core. It generalises the single-write, dual-read file in width, depth, read-port count and write-port count. It adds synchronous clearing, optional same-cycle write-to-read bypass, and a per-register busy scoreboard that the issue stage uses for hazard detection. It sits between decode/issue, which drives the read and claim ports, and writeback, which drives the write ports.

## Interface

- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥ 2. Register 0 is hardwired to zero.
- NR, 2, number of read ports, ≥ 1.
- NW, 1, number of write ports, ≥ 1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- AW is a localparam equal to $clog2(NREGS); it is not overridable.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; **already decided**: synchronous, active-high.
- we  in  NW  per-port write enable.
- wa  in  NW*AW  write addresses; port i occupies bits [i*AW +: AW].
- wd  in  NW*XLEN  write data; port i occupies bits [i*XLEN +: XLEN].
- ra  in  NR*AW  read addresses, packed the same way as wa.
- rd  out  NR*XLEN  read data, combinational.
- rbusy  out  NR  per-read-port busy flag for the addressed register, combinational.
- claim_en  in  1  marks register claim_a as having a write in flight.
- claim_a  in  AW  register to claim.
- dbg_a  in  AW  debug read address.
- dbg_d  out  XLEN  debug read data; stored value only, never bypassed.

## Operation

- **State**
  - regs[1..NREGS-1], each XLEN bits.
  - busy[1..NREGS-1], 1 bit each.
  - Register 0 has no storage and no busy bit.
- **Reset**
  - rst=1 at a rising edge sets every regs entry to 0 and every busy bit to 0.
  - Reset overrides all writes and claims presented in that cycle.
- **Write**
  - At the edge, port i with we[i]=1 and wa[i]≠0 stores wd[i] into regs[wa[i]] and clears busy[wa[i]].
  - Writes addressed to 0 are discarded entirely.
- **Write collision**
  - When two or more enabled ports target the same nonzero address, the highest-index port wins.
  - Ports targeting different addresses all commit in the same cycle.
- **Read**
  - For each read port j: if ra[j]=0, then rd[j]=0 and rbusy[j]=0.
  - Otherwise, with BYPASS=1 and some enabled write port targeting ra[j] this cycle:
    - rd[j] = wd of the winning (highest-index) such port;
    - rbusy[j] = 0, unless claim_en=1 and claim_a=ra[j] in the same cycle, in which case the claim still takes effect at the edge but rbusy[j] is still 0 this cycle.
  - Otherwise rd[j] = regs[ra[j]] and rbusy[j] = busy[ra[j]].
- **Claim**
  - At the edge, claim_en=1 with claim_a≠0 sets busy[claim_a].
  - A claim of register 0 is ignored.
- **Claim and write to the same register in the same cycle**
  - The claim wins: busy ends at 1 and the write data is still stored.
  - Rationale: the claim belongs to a younger instruction.
- **Debug port**
  - dbg_d = regs[dbg_a], or 0 when dbg_a=0.

## Timing

- **Reads**
  - rd and rbusy: zero-latency combinational paths from ra, regs and busy.
  - With BYPASS=1 they also depend combinationally on we, wa and wd.
- **Writes and claims**
  - Visible through the stored path on the cycle after the edge.
  - With BYPASS=1, write data is visible on rd in the same cycle.
- **Outputs after reset**
  - All rd = 0, all rbusy = 0, dbg_d = 0, for any addresses.
- **Reset asserted mid-operation**
  - Writes, claims and busy state in flight are all lost; no partial update.
  - During rst=1, outputs still follow the combinational rules using the current stored state.
  - The clear appears on the cycle after the edge.
- **Sustained throughput**
  - NW writes, NR reads and 1 claim per cycle, with no stalls.
- **Address range**
  - Address widths cover NREGS exactly, so no out-of-range addresses exist.

## Test plan

- **Reset clear.** Write 0xDEADBEEF to x5, then pulse rst=1 for one cycle with we[0]=1, wa=5, wd=0x1 → the next cycle shows rd(ra=5)=0 and rbusy=0.
- **Write/read and x0.** Write x1=0x12345678 and x0=0xFFFFFFFF → the next cycle rd(ra=1)=0x12345678, rd(ra=0)=0, dbg_d(dbg_a=0)=0.
- **Bypass.**
  - BYPASS=1: while writing x7=0xA5A5A5A5 with read ra=7 in the same cycle (old value 0) → rd=0xA5A5A5A5 that cycle.
  - BYPASS=0, same stimulus → rd=0, then 0xA5A5A5A5 on the following cycle.
- **Write collision.** NW=2, both ports write x3 (port0=0x11, port1=0x22) → regs[3]=0x22, and the same-cycle bypass read of x3 returns 0x22.
- **Scoreboard.**
  - Claim x9 → rbusy(ra=9)=1 next cycle.
  - Write x9=0x55 → rbusy=0 that cycle with BYPASS=1, and 0 stored afterwards.
  - Claim and write x9 in the same cycle → rbusy=1 next cycle and rd=0x55.
- **Claim x0.** claim_en=1, claim_a=0 → rbusy(ra=0) stays 0; no busy bit changes.
